fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Command-side issue stage directly upstream of the FPU core. It accepts FP commands (operands, opcode, tag) over a valid/ready interface into a small FIFO. It drives one command at a time onto the core's operand/Operation inputs and captures the core's registered result and flags one cycle later. It returns the result with its tag over a valid/ready response interface, so the core's free-running, opcode-per-cycle interface becomes a flow-controlled transaction port.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2
TAG_W, 4, width of the opaque command tag carried to the response

Ports:
Clk  in  1  clock
RstN  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_a  in  32  operand A, IEEE-754 single precision
cmd_b  in  32  operand B
cmd_op  in  4  0 add, 1 sub, 2 mul, 3 div; other values illegal
cmd_tag  in  TAG_W  command tag
core_a  out  32  to core a_operand
core_b  out  32  to core b_operand
core_op  out  4  to core Operation
core_result  in  32  from core FPU_Output
core_exc  in  1  from core Exception
core_ovf  in  1  from core Overflow
core_unf  in  1  from core Underflow
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_data  out  32  result
rsp_flags  out  3  {underflow, overflow, exception}
rsp_tag  out  TAG_W  tag of the originating command

Behaviour:
- Reset: clock Clk; reset RstN, asynchronous, active-low. Reset empties the FIFO, sets state IDLE and clears cmd_ready to 0.
- Outputs in reset: core_a = 0, core_b = 0, core_op = 4'hF (NOP), rsp_valid = 0, rsp_data = 0, rsp_flags = 0, rsp_tag = 0.
- Ready after reset: cmd_ready = !full from the first cycle after reset deasserts.
- FIFO: circular buffer with log2(DEPTH)+1-bit pointers. The MSB differs when full.
  - Push on cmd_valid & cmd_ready.
  - Pop only under the FSM conditions below.
  - Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle are both legal and leave the count unchanged.
  - When full, cmd_ready = 0, so there is no push even if a pop occurs that cycle.
- FSM states are IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO is not empty, pop the head into the op registers (a, b, op, tag).
    - Legal op: next state ISSUE.
    - Illegal op: rsp_data = 0, rsp_flags = 3'b001, rsp_tag = tag; next state RESP. The core is not issued.
  - ISSUE: core_a/core_b/core_op are driven from the op registers. The core samples them at the end of this cycle. Next state WAIT.
  - WAIT: core inputs are held unchanged. At the end of the cycle, capture rsp_data = core_result, rsp_flags = {core_unf, core_ovf, core_exc}, rsp_tag = tag. Next state RESP.
  - RESP: rsp_valid = 1. rsp_* stay stable until the handshake. core_op = 4'hF and core_a/core_b = 0.
    - rsp_ready & FIFO not empty: pop and go to ISSUE, or go straight to RESP if the popped op is illegal.
    - rsp_ready & FIFO empty: go to IDLE.
    - No rsp_ready: stay in RESP.
- core_op = 4'hF in IDLE and RESP, so the core output register returns to zero and never holds stale flags.
- Latency: command accepted in cycle N gives rsp_valid in cycle N+4 (IDLE pop N+1, ISSUE N+2, WAIT N+3).
- Throughput: one result per 3 cycles with rsp_ready tied high and the FIFO non-empty.
- Ordering: responses return in strict command order.
- Reset mid-operation: any state aborts immediately. In-flight and queued commands are discarded with no response.

Optional Feature:
- Macro: FPU_ISSUE_STATS_EN.
- Defined: adds outputs stat_issued[15:0] and stat_exc[15:0].
  - stat_issued increments on each rsp handshake.
  - stat_exc increments on each rsp handshake with rsp_flags[0] = 1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package fpu_pkg:
  - opcode constants OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3, OP_NOP = 4'hF
  - state enum
  - flag bit indices FLG_EXC = 0, FLG_OVF = 1, FLG_UNF = 2
  - command struct {a, b, op, tag}
- Sub-module fpu_cmd_fifo (parameterised DEPTH/width, push/pop/full/empty). The FSM lives in fpu_issue_ctrl.

Test Plan:
- Single add: cmd a = 0x3F800000, b = 0x40000000, op = 0, tag = 5, rsp_ready = 1, accepted at cycle N -> rsp_valid at N+4 with data 0x40400000, flags 0, tag 5, for exactly one cycle.
- Back-to-back ordering: push mul (0x40000000 × 0x40400000, tag 1) then div (0x40C00000 / 0x40000000, tag 2) -> responses 0x40C00000 tag 1, then 0x40400000 tag 2, in that order, 3 cycles apart.
- Backpressure and full: rsp_ready = 0, push DEPTH+2 commands -> cmd_ready drops once DEPTH are queued plus one held in RESP. rsp_* stay stable while stalled. Releasing rsp_ready drains all commands in order and cmd_ready returns to 1.
- Illegal op: op = 5, tag = 3 -> rsp_data 0, flags 3'b001, tag 3; core_op stays 4'hF throughout.
- Reset mid-operation: assert RstN low during WAIT with 2 queued commands -> all outputs at reset values immediately; after release no response appears and cmd_ready = 1.
- FPU_ISSUE_STATS_EN: 3 legal ops plus 1 illegal -> stat_issued = 4, stat_exc = 1.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, FSM states, flag indices and operand bundle
// shared by the FPU issue stage.
package fpu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  localparam int FLG_EXC = 0;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } fp_cmd_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_if: command and response valid/ready channels
// of the FPU issue stage.
interface fpu_issue_if #(
  parameter int TAG_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [3:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [2:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_a, cmd_b,
    output cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid,
    input  rsp_data, rsp_flags, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b,
    input  cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid,
    output rsp_data, rsp_flags, rsp_tag
  );

endinterface

// File: rtl/fpu_issue_ctrl_fifo.sv
// fpu_cmd_fifo: circular command buffer, DEPTH a power of two,
// pointers carry one extra wrap bit to tell full from empty.
module fpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: turns the free-running FPU core port into a
// flow-controlled transaction port. Option: FPU_ISSUE_STATS_EN.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic        Clk,
  input  logic        RstN,
  fpu_issue_if.slave  bus,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [3:0]  core_op,
  input  logic [31:0] core_result,
  input  logic        core_exc,
  input  logic        core_ovf,
  input  logic        core_unf
`ifdef FPU_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_exc
`endif
);

  typedef struct packed {
    fp_cmd_t          f;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             push_d;
  cmd_t             head;
  cmd_t             op_q;
  cmd_t             op_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             load;
  logic             rdy_q;
  state_t           state_q;
  state_t           state_d;
  logic [31:0]      data_q;
  logic [31:0]      data_d;
  logic [2:0]       flags_q;
  logic [2:0]       flags_d;
  logic [TAG_W-1:0] rtag_q;
  logic [TAG_W-1:0] rtag_d;
  logic             st_idle;
  logic             st_issue;
  logic             st_wait;
  logic             st_resp;
  logic             drive;

  assign push_d = {bus.cmd_a, bus.cmd_b,
                   bus.cmd_op, bus.cmd_tag};

  assign bus.cmd_ready = rdy_q & ~full;
  assign push = bus.cmd_valid & bus.cmd_ready;

  fpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .Clk     (Clk),
    .RstN    (RstN),
    .push_i  (push),
    .data_i  (push_d),
    .pop_i   (load),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign st_idle  = (state_q == ST_IDLE);
  assign st_issue = (state_q == ST_ISSUE);
  assign st_wait  = (state_q == ST_WAIT);
  assign st_resp  = (state_q == ST_RESP);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;
    rtag_d  = rtag_q;
    load    = 1'b0;
    unique case (1'b1)
      st_idle: load = ~empty;
      st_issue: state_d = ST_WAIT;
      st_wait: begin
        state_d          = ST_RESP;
        data_d           = core_result;
        flags_d[FLG_EXC] = core_exc;
        flags_d[FLG_OVF] = core_ovf;
        flags_d[FLG_UNF] = core_unf;
        rtag_d           = op_q.tag;
      end
      st_resp: begin
        if (bus.rsp_ready) begin
          load = ~empty;
          if (empty) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // illegal opcodes bypass the core and answer at once
    if (load) begin
      op_d = head;
      if (op_legal(head.f.op)) begin
        state_d = ST_ISSUE;
      end else begin
        state_d          = ST_RESP;
        data_d           = '0;
        flags_d          = '0;
        flags_d[FLG_EXC] = 1'b1;
        rtag_d           = head.tag;
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rdy_q   <= 1'b0;
      state_q <= ST_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
      rtag_q  <= '0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      rtag_q  <= rtag_d;
    end
  end

  assign drive   = st_issue | st_wait;
  assign core_a  = drive ? op_q.f.a : '0;
  assign core_b  = drive ? op_q.f.b : '0;
  assign core_op = drive ? op_q.f.op : OP_NOP;

  assign bus.rsp_valid = st_resp;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;
  assign bus.rsp_tag   = rtag_q;

`ifdef FPU_ISSUE_STATS_EN
  logic        hs;
  logic [15:0] issued_q;
  logic [15:0] exc_q;

  assign hs = st_resp & bus.rsp_ready;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      issued_q <= '0;
      exc_q    <= '0;
    end else if (hs) begin
      if (issued_q != 16'hFFFF)
        issued_q <= issued_q + 1'b1;
      if (flags_q[FLG_EXC] && exc_q != 16'hFFFF)
        exc_q <= exc_q + 1'b1;
    end
  end

  assign stat_issued = issued_q;
  assign stat_exc    = exc_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed plus random checks of fpu_issue_ctrl
// against a queue-based response model and a stub FPU core.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic Clk  = 1'b0;
  logic RstN = 1'b0;
  always #5 Clk = ~Clk;

  fpu_issue_if #(.TAG_W(TAG_W)) bus ();

  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [3:0]  core_op;
  logic [31:0] core_result;
  logic        core_exc;
  logic        core_ovf;
  logic        core_unf;
`ifdef FPU_ISSUE_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_exc;
`endif

  fpu_issue_ctrl #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .Clk         (Clk),
    .RstN        (RstN),
    .bus         (bus),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_op     (core_op),
    .core_result (core_result),
    .core_exc    (core_exc),
    .core_ovf    (core_ovf),
    .core_unf    (core_unf)
`ifdef FPU_ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_exc    (stat_exc)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_rsp = 0;
  int n_exc = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  // stub core: IEEE results for the named vectors, a hash otherwise
  // returns {unf, ovf, exc, result}
  function automatic logic [34:0] core_fn(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op
  );
    logic [31:0] r;
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000)
      return {3'b000, 32'h40400000};
    if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000)
      return {3'b000, 32'h40C00000};
    if (op == OP_DIV && a == 32'h40C00000 && b == 32'h40000000)
      return {3'b000, 32'h40400000};
    r = (a ^ {b[15:0], b[31:16]}) + (32'h9E3779B9 * {28'd0, op});
    return {r[31], r[17] & r[3], r[9], r};
  endfunction

  always @(posedge Clk) begin
    if (core_op == OP_NOP)
      {core_unf, core_ovf, core_exc, core_result} <= 35'd0;
    else
      {core_unf, core_ovf, core_exc, core_result} <=
        core_fn(core_a, core_b, core_op);
  end

  typedef struct packed {
    logic [31:0]      d;
    logic [2:0]       f;
    logic [TAG_W-1:0] t;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e;

  function automatic rsp_t model(
    input logic [31:0]      a,
    input logic [31:0]      b,
    input logic [3:0]       op,
    input logic [TAG_W-1:0] t
  );
    rsp_t        r;
    logic [34:0] c;
    if (op > 4'd3) begin
      r.d = 32'd0;
      r.f = 3'b001;
    end else begin
      c   = core_fn(a, b, op);
      r.d = c[31:0];
      r.f = c[34:32];
    end
    r.t = t;
    return r;
  endfunction

  always @(negedge Clk) begin
    if (RstN) begin
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(model(bus.cmd_a, bus.cmd_b,
                              bus.cmd_op, bus.cmd_tag));
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_data", 64'(bus.rsp_data), 64'(e.d));
          chk("rsp_flags", 64'(bus.rsp_flags), 64'(e.f));
          chk("rsp_tag", 64'(bus.rsp_tag), 64'(e.t));
          n_rsp++;
          if (e.f[0]) n_exc++;
        end
      end
      chk("core_op_ok",
          64'(core_op <= 4'd3 || core_op == OP_NOP), 64'd1);
    end
  end

  task automatic send(input logic [31:0]      a,
                      input logic [31:0]      b,
                      input logic [3:0]       op,
                      input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_tag   = t;
    do begin
      @(negedge Clk);
      n++;
    end while (!bus.cmd_ready && n < 100);
    chk("send_accept", 64'(bus.cmd_ready), 64'd1);
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((exp_q.size() != 0 || bus.rsp_valid) && n < lim);
    chk("drain", 64'(exp_q.size() == 0 && !bus.rsp_valid), 64'd1);
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
    chk({p, "_core_a"}, 64'(core_a), 64'd0);
    chk({p, "_core_b"}, 64'(core_b), 64'd0);
    chk({p, "_core_op"}, 64'(core_op), 64'(OP_NOP));
    chk({p, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({p, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
    chk({p, "_rsp_flags"}, 64'(bus.rsp_flags), 64'd0);
    chk({p, "_rsp_tag"}, 64'(bus.rsp_tag), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          got;
    int          c;
    int          t1;
    int          t2;
    int          n0;
    logic        seen;
    logic        hs;
    logic [31:0] pa;
    logic [31:0] pb;

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;
    hs            = 1'b0;
    t1            = 0;
    t2            = 0;

    // reset values, then ready one cycle after release
    RstN = 1'b0;
    repeat (3) @(negedge Clk);
    chk_rst("rst");
    RstN = 1'b1;
    @(negedge Clk);
    chk("ready_after_rst", 64'(bus.cmd_ready), 64'd1);

    // single add: rsp_valid four cycles after acceptance
    @(posedge Clk);
    #1;
    bus.rsp_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, OP_ADD, 4'd5);
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (lat < 12) begin
      @(negedge Clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    chk("add_latency", 64'(lat), 64'd4);
    chk("add_data", 64'(bus.rsp_data), 64'h40400000);
    chk("add_flags", 64'(bus.rsp_flags), 64'd0);
    chk("add_tag", 64'(bus.rsp_tag), 64'd5);
    @(negedge Clk);
    chk("add_one_cycle", 64'(bus.rsp_valid), 64'd0);

    // back-to-back ordering, three cycles apart
    @(posedge Clk);
    #1;
    send(32'h40000000, 32'h40400000, OP_MUL, 4'd1);
    send(32'h40C00000, 32'h40000000, OP_DIV, 4'd2);
    bus.cmd_valid = 1'b0;
    got = 0;
    c = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      @(negedge Clk);
      c++;
      if (bus.rsp_valid) begin
        if (got == 0) begin
          t1 = c;
          chk("b2b_d0", 64'(bus.rsp_data), 64'h40C00000);
          chk("b2b_t0", 64'(bus.rsp_tag), 64'd1);
        end else begin
          t2 = c;
          chk("b2b_d1", 64'(bus.rsp_data), 64'h40400000);
          chk("b2b_t1", 64'(bus.rsp_tag), 64'd2);
        end
        got++;
      end
    end
    chk("b2b_count", 64'(got), 64'd2);
    chk("b2b_gap", 64'(t2 - t1), 64'd3);

    // backpressure: DEPTH queued plus one held in RESP
    @(posedge Clk);
    #1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      send($urandom, $urandom, 4'($urandom_range(0, 3)),
           TAG_W'(8 + i));
    pa = $urandom;
    pb = $urandom;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = pa;
    bus.cmd_b     = pb;
    bus.cmd_op    = OP_SUB;
    bus.cmd_tag   = 4'd15;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("bp_ready_low", 64'(bus.cmd_ready), 64'd0);
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_rsp_data", 64'(bus.rsp_data), 64'(exp_q[0].d));
      chk("bp_rsp_tag", 64'(bus.rsp_tag), 64'(exp_q[0].t));
    end
    n0 = n_rsp;
    @(posedge Clk);
    #1;
    bus.rsp_ready = 1'b1;
    send(pa, pb, OP_SUB, 4'd15);
    bus.cmd_valid = 1'b0;
    drain(100);
    chk("bp_drained", 64'(n_rsp - n0), 64'(DEPTH + 2));
    chk("bp_ready_back", 64'(bus.cmd_ready), 64'd1);

    // illegal opcode answered without touching the core
    @(posedge Clk);
    #1;
    send($urandom, $urandom, 4'd5, 4'd3);
    bus.cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
      chk("ill_core_nop", 64'(core_op), 64'(OP_NOP));
    end while (!bus.rsp_valid && lat < 10);
    chk("ill_latency", 64'(lat), 64'd2);
    chk("ill_data", 64'(bus.rsp_data), 64'd0);
    chk("ill_flags", 64'(bus.rsp_flags), 64'b001);
    chk("ill_tag", 64'(bus.rsp_tag), 64'd3);
    @(negedge Clk);
    chk("ill_one_cycle", 64'(bus.rsp_valid), 64'd0);

    // reset during WAIT with two commands queued
    @(posedge Clk);
    #1;
    send(32'h40000000, 32'h40400000, OP_MUL, 4'd1);
    send($urandom, $urandom, OP_ADD, 4'd2);
    send($urandom, $urandom, OP_SUB, 4'd3);
    bus.cmd_valid = 1'b0;
    chk("mid_core_op", 64'(core_op), 64'(OP_MUL));
    chk("mid_core_a", 64'(core_a), 64'h40000000);
    RstN = 1'b0;
    exp_q.delete();
    n_rsp = 0;
    n_exc = 0;
    #1;
    chk_rst("mid_rst");
    repeat (2) @(negedge Clk);
    RstN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rst_no_rsp", 64'(seen), 64'd0);
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);

    // three legal plus one illegal since reset
    @(posedge Clk);
    #1;
    send(32'h3F800000, 32'h40000000, OP_ADD, 4'd10);
    send(32'h40000000, 32'h40400000, OP_MUL, 4'd11);
    send(32'h40C00000, 32'h40000000, OP_DIV, 4'd12);
    send($urandom, $urandom, 4'd9, 4'd13);
    bus.cmd_valid = 1'b0;
    drain(100);
    chk("four_rsp", 64'(n_rsp), 64'd4);
`ifdef FPU_ISSUE_STATS_EN
    chk("stat_issued_4", 64'(stat_issued), 64'd4);
    chk("stat_exc_1", 64'(stat_exc), 64'd1);
`endif

    // random traffic with random response backpressure
    @(posedge Clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.cmd_valid || hs) begin
        bus.cmd_valid = ($urandom_range(0, 3) != 0);
        bus.cmd_a     = $urandom;
        bus.cmd_b     = $urandom;
        bus.cmd_op    = ($urandom_range(0, 7) == 0) ?
                        4'($urandom_range(4, 15)) :
                        4'($urandom_range(0, 3));
        bus.cmd_tag   = TAG_W'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge Clk);
      hs = bus.cmd_valid && bus.cmd_ready;
      @(posedge Clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain(200);
    chk("rand_ready", 64'(bus.cmd_ready), 64'd1);
`ifdef FPU_ISSUE_STATS_EN
    chk("stat_issued_rand", 64'(stat_issued), 64'(n_rsp));
    chk("stat_exc_rand", 64'(stat_exc), 64'(n_exc));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
